muldiv_sequencer: RTL and testbench

- Iterative multi-cycle sequencer for the RV32M multiply/divide operations.
- Sits beside the single-cycle ALU in the execute stage. The decode path selects it for OP_ALU_R with funct7 = 0000001.
- Accepts one operation at a time through a start/busy handshake and computes it with a shift-add or restoring-divide datapath.
- Returns a registered result with a one-cycle valid pulse, and holds the pipeline via busy.

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the RV32M
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] result;

  // Execute stage side: issues ops, watches busy/valid/result.
  modport master (
    output start, funct3, a, b, flush,
    input  busy, valid, result
  );

  // Sequencer side.
  modport slave (
    input  start, funct3, a, b, flush,
    output busy, valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer. One operation at a time:
// a shift-add multiply or a restoring divide over WIDTH cycles. Both
// algorithms share a single 2*WIDTH accumulator:
//   - multiply: {partial product high, multiplier shifting out}
//   - divide:   {partial remainder, dividend shifting into quotient}
// Division special cases (b==0, signed overflow) skip the iterations.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic               neg_q;     // product / quotient sign
  logic               neg_r;     // remainder sign
  logic               special_r; // acc low half already holds the answer
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   final_val;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;

  // Request decode; only meaningful in the cycle the op is accepted.
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, special, accept;
  logic [WIDTH-1:0] a_mag, b_mag, special_val;

  always_comb begin
    is_div      = bus.funct3[2];
    a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
    a_neg       = a_signed && bus.a[WIDTH-1];
    b_neg       = b_signed && bus.b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    a_mag       = a_neg ? -bus.a : bus.a;
    b_mag       = b_neg ? -bus.b : bus.b;
    div_zero    = is_div && (bus.b == '0);
    div_ovf     = is_div && !bus.funct3[0] && (bus.a == MOST_NEG) && (bus.b == '1);
    special     = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)     special_val = bus.funct3[1] ? bus.a : '1;
    else if (div_ovf) special_val = bus.funct3[1] ? '0 : bus.a;
    accept      = (state == IDLE) && bus.start && !bus.flush;
  end

  // One iteration of whichever algorithm the latched op selects.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_shift;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    // Compare on WIDTH+1 bits: the shifted remainder can exceed WIDTH bits.
    div_ge    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} >= {1'b0, opnd};
    if (op[2])
      acc_nxt = {(div_ge ? div_shift - opnd : div_shift), acc[WIDTH-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction and selection of the architectural result.
  logic [2*WIDTH-1:0] prod_signed;

  always_comb begin
    prod_signed = neg_q ? -acc : acc;
    final_val   = '0;
    if (special_r)          final_val = acc[WIDTH-1:0];
    else if (!op[2])        final_val = (op[1:0] == 2'b00) ? prod_signed[WIDTH-1:0]
                                                           : prod_signed[2*WIDTH-1:WIDTH];
    else if (!op[1])        final_val = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    else                    final_val = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: flush aborts COMPUTE and DONE; DONE always falls to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : COMPUTE;
      COMPUTE: if (bus.flush)     state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate, publish result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_r <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op        <= bus.funct3;
          neg_q     <= a_neg ^ b_neg;
          neg_r     <= a_neg;
          special_r <= special;
          opnd      <= b_mag;
          acc       <= {{WIDTH{1'b0}}, (special ? special_val : a_mag)};
          cnt       <= CW'(WIDTH-1);
        end
        COMPUTE: if (!bus.flush) begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
        end
        DONE: if (!bus.flush) begin
          valid_q  <= 1'b1;
          result_q <= final_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors plus random
// ops checked against a plain-arithmetic RV32M reference.
module tb_muldiv_sequencer;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference result from RV32M semantics using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    q  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accept edge to valid: 1 for division special cases.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == MOST_NEG && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return MOST_NEG;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait (bounded) for valid. lat=-1 on timeout.
  // bcnt counts sampled cycles with busy high before valid.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt, output logic [31:0] res);
    bus.funct3 = f3; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; bcnt = 0; res = '0;
    for (int c = 0; c <= 40; c++) begin
      if (bus.valid) begin lat = c; res = bus.result; break; end
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic();
    int lat, bcnt; logic [31:0] res;
    do_op(3'd0, 32'd7, 32'd6, lat, bcnt, res);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++; if (bcnt !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d want 33", bcnt); end
    checks++; if (res !== 32'h2A) begin errors++; $display("FAIL mul_result got %h want 0000002a", res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_valid got %b want 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse got %b want 0", bus.valid); end
    checks++; if (bus.result !== 32'h2A) begin errors++; $display("FAIL mul_result_hold got %h want 0000002a", bus.result); end
  endtask

  task automatic test_directed();
    logic [2:0]  f3  [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0};
    logic [31:0] av  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
                              32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7,
                              32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [12] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14,
                              32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'h00000001};
    int          elat[12] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    int lat, bcnt; logic [31:0] res;
    for (int i = 0; i < 12; i++) begin
      do_op(f3[i], av[i], bv[i], lat, bcnt, res);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL directed_%0d_result got %h want %h", i, res, exp[i]); end
      checks++;
      if (lat !== elat[i]) begin errors++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, elat[i]); end
    end
  endtask

  task automatic test_random();
    int lat, bcnt; logic [31:0] res, a, b, e; logic [2:0] f3;
    for (int i = 0; i < 48; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      e  = model(f3, a, b);
      do_op(f3, a, b, lat, bcnt, res);
      checks++;
      if (res !== e || lat !== model_lat(f3, a, b)) begin
        errors++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h got %h/lat %0d want %h/lat %0d",
                 i, f3, a, b, res, lat, e, model_lat(f3, a, b));
      end
    end
  endtask

  task automatic test_flush();
    int lat, bcnt, nvalid; logic [31:0] res, prev;
    prev = bus.result;
    bus.funct3 = 3'd0; bus.a = 32'd1234; bus.b = 32'd5678; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    nvalid = 0;
    repeat (40) begin if (bus.valid) nvalid++; @(posedge clk); #1; end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL flush_no_valid got %0d pulses want 0", nvalid); end
    checks++; if (bus.result !== prev) begin errors++; $display("FAIL flush_result_hold got %h want %h", bus.result, prev); end
    do_op(3'd0, 32'd3, 32'd3, lat, bcnt, res);
    checks++; if (res !== 32'd9 || lat !== 33) begin errors++; $display("FAIL flush_followup got %h/lat %0d want 00000009/lat 33", res, lat); end
  endtask

  task automatic test_flush_idle_and_done();
    int nvalid; logic [31:0] prev;
    // flush with start in IDLE: start must be ignored
    bus.funct3 = 3'd0; bus.a = 32'd2; bus.b = 32'd2; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept got busy %b want 0", bus.busy); end
    // flush landing on the DONE cycle beats completion
    prev = bus.result;
    bus.a = 32'd11; bus.b = 32'd13; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    nvalid = 0;
    repeat (5) begin if (bus.valid) nvalid++; @(posedge clk); #1; end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL flush_done_valid got %0d pulses want 0", nvalid); end
    checks++; if (bus.result !== prev) begin errors++; $display("FAIL flush_done_result got %h want %h", bus.result, prev); end
  endtask

  task automatic test_back_to_back();
    int nvalid, lat, bcnt; logic [31:0] res;
    bus.funct3 = 3'd0; bus.a = 32'd21; bus.b = 32'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    for (int c = 0; c <= 33; c++) begin
      if (bus.valid) nvalid++;
      if (c <= 32 && bus.busy !== 1'b1) begin errors++; checks++; $display("FAIL b2b_busy_c%0d got 0 want 1", c); end
      @(posedge clk); #1;
    end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL b2b_valid_count got %0d want 1", nvalid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got busy %b want 1", bus.busy); end
    bus.start = 1'b0;
    lat = -1; res = '0; bcnt = 0;
    for (int c = 0; c <= 40; c++) begin
      if (bus.valid) begin lat = c; res = bus.result; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat < 0 || res !== 32'd42) begin errors++; $display("FAIL b2b_second got %h/lat %0d want 0000002a", res, lat); end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    bus.funct3 = 3'd4; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 32'h0) begin
      errors++; $display("FAIL reset_mid got busy %b valid %b result %h want 0 0 0", bus.busy, bus.valid, bus.result);
    end
    @(negedge clk); rst = 1'b0;
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.valid) nvalid++; end
    checks++; if (nvalid !== 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_after got %0d pulses busy %b want 0 0", nvalid, bus.busy); end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
    test_reset();
    test_mul_basic();
    test_directed();
    test_random();
    test_flush();
    test_flush_idle_and_done();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
